matrix_keypad_scanner: RTL and testbench

Scans a 4x4 active-low matrix keypad by driving one row low at a time and sampling the column lines. Debounces whole-frame snapshots and emits a one-cycle press event carrying a 4-bit key code, plus a held level and a release event. It is the input-side counterpart of the multiplexed seven-segment display scanner and feeds key codes to counter and control logic in the same FPGA lab designs.

---
 rtl/matrix_keypad_scanner_if.sv | 19 +
 rtl/matrix_keypad_scanner.sv | 152 +++++++++++++++
 tb/tb_matrix_keypad_scanner.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_keypad_scanner_if.sv
// Keypad matrix lines and decoded key events shared between the scanner and its consumers.
interface matrix_keypad_scanner_if;
   logic [3:0] col;
   logic [3:0] row;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;
   logic       key_release;

   modport master (
      input  col,
      output row, key_code, key_valid, key_held, key_release
   );

   modport slave (
      output col,
      input  row, key_code, key_valid, key_held, key_release
   );
endinterface

// File: rtl/matrix_keypad_scanner.sv
// 4x4 active-low keypad scanner: row strobing, whole-frame debounce and press/release events.
module matrix_keypad_scanner #(
   parameter int unsigned F_CLK         = 50000000,
   parameter int unsigned F_SCAN        = 1000,
   parameter int unsigned STABLE_FRAMES = 3
) (
   input  logic                           clk,
   input  logic                           rst_n,
   matrix_keypad_scanner_if.master        kp
);
   localparam int unsigned       T         = F_CLK / F_SCAN;
   localparam int unsigned       CNT_W     = (T > 1) ? $clog2(T) : 1;
   localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(T - 1);
   localparam logic [3:0]        STABLE_N  = 4'(STABLE_FRAMES);

   typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_kind_e;
   typedef struct packed {
      cls_kind_e  kind;
      logic [3:0] key;
   } cls_t;
   typedef enum logic {ST_IDLE, ST_PRESSED} state_e;

   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       row_idx_q, row_idx_d;
   logic [3:0]       row_q;
   logic [3:0]       col_s1_q, col_s2_q;
   logic [15:0]      snap_q;
   logic             frame_done_q;
   cls_t             prev_cls_q, frame_cls, stable_cls_q;
   logic [3:0]       stable_cnt_q, stable_cnt_d;
   logic             stable_q, stable_d;
   state_e           state_q;
   logic [3:0]       key_code_q;
   logic             key_valid_q, key_held_q, key_release_q;
   logic             tick;
   logic [4:0]       ones;
   logic [3:0]       single_key;

   assign tick      = (cnt_q == TICK_LAST);
   assign row_idx_d = row_idx_q + 2'd1;
   assign ones      = 5'($countones(snap_q));

   always_comb begin
      single_key = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (snap_q[i]) single_key = 4'(i);
      end
      frame_cls.kind = CLS_NONE;
      frame_cls.key  = 4'd0;
      if (ones == 5'd1) begin
         frame_cls.kind = CLS_SINGLE;
         frame_cls.key  = single_key;
      end else if (ones > 5'd1) begin
         frame_cls.kind = CLS_MULTI;
      end
   end

   // A class is announced only on the frame where its run length first hits the threshold.
   always_comb begin
      stable_cnt_d = 4'd1;
      stable_d     = (STABLE_N == 4'd1);
      if (frame_cls == prev_cls_q) begin
         stable_cnt_d = (stable_cnt_q >= STABLE_N) ? STABLE_N : stable_cnt_q + 4'd1;
         stable_d     = (stable_cnt_q < STABLE_N) && (stable_cnt_q + 4'd1 == STABLE_N);
      end
   end

   // Scan: tick counter, row strobe, column synchronizer, frame snapshot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         row_idx_q    <= 2'd0;
         row_q        <= 4'b1110;
         col_s1_q     <= 4'b1111;
         col_s2_q     <= 4'b1111;
         snap_q       <= 16'd0;
         frame_done_q <= 1'b0;
      end else begin
         col_s1_q     <= kp.col;
         col_s2_q     <= col_s1_q;
         frame_done_q <= tick && (row_idx_q == 2'd3);
         if (tick) begin
            cnt_q                       <= '0;
            snap_q[{row_idx_q, 2'b00} +: 4] <= ~col_s2_q;
            row_idx_q                   <= row_idx_d;
            row_q                       <= ~(4'b0001 << row_idx_d);
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Debounce: one clock after the frame completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_cls_q.kind   <= CLS_NONE;
         prev_cls_q.key    <= 4'd0;
         stable_cls_q.kind <= CLS_NONE;
         stable_cls_q.key  <= 4'd0;
         stable_cnt_q      <= 4'd0;
         stable_q          <= 1'b0;
      end else begin
         stable_q <= 1'b0;
         if (frame_done_q) begin
            prev_cls_q   <= frame_cls;
            stable_cnt_q <= stable_cnt_d;
            stable_q     <= stable_d;
            stable_cls_q <= frame_cls;
         end
      end
   end

   // Key FSM: acts on the stable pulse, two clocks after the row-3 sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         key_code_q    <= 4'd0;
         key_valid_q   <= 1'b0;
         key_held_q    <= 1'b0;
         key_release_q <= 1'b0;
      end else begin
         key_valid_q   <= 1'b0;
         key_release_q <= 1'b0;
         if (stable_q) begin
            case (state_q)
               ST_IDLE: begin
                  if (stable_cls_q.kind == CLS_SINGLE) begin
                     state_q     <= ST_PRESSED;
                     key_code_q  <= stable_cls_q.key;
                     key_held_q  <= 1'b1;
                     key_valid_q <= 1'b1;
                  end
               end
               ST_PRESSED: begin
                  if (stable_cls_q.kind == CLS_NONE) begin
                     state_q       <= ST_IDLE;
                     key_held_q    <= 1'b0;
                     key_release_q <= 1'b1;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign kp.row         = row_q;
   assign kp.key_code    = key_code_q;
   assign kp.key_valid   = key_valid_q;
   assign kp.key_held    = key_held_q;
   assign kp.key_release = key_release_q;
endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Randomized and directed bench for matrix_keypad_scanner against a frame-level keypad model.
module tb_matrix_keypad_scanner;
   localparam int T = 10;
   localparam int S = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] pressed = 16'd0;
   bit          chk_en = 1'b0;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          ev_valid = 0;
   int          ev_rel = 0;

   matrix_keypad_scanner_if kp();

   matrix_keypad_scanner #(
      .F_CLK(100), .F_SCAN(10), .STABLE_FRAMES(S)
   ) dut (
      .clk(clk), .rst_n(rst_n), .kp(kp)
   );

   always #5 clk = ~clk;

   // Keypad: a column is pulled low when any pressed key in it sits on the driven row.
   always_comb begin
      kp.col = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !kp.row[r]) kp.col[c] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: classes are ints (-1 none, 0..15 single key, 16 multi).
   int          m_n, m_last, m_run, m_due, m_pend, m_ri, m_cls;
   logic [3:0]  m_hist1, m_hist2, m_sampled, m_row, m_code;
   logic [15:0] m_frame;
   bit          m_held, m_valid, m_release;

   function automatic int classify(input logic [15:0] f);
      int ones;
      ones = $countones(f);
      if (ones == 0) return -1;
      if (ones > 1) return 16;
      for (int i = 0; i < 16; i++) if (f[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_n = 0; m_last = -1; m_run = 0; m_due = -1; m_pend = -1;
      m_hist1 = 4'hF; m_hist2 = 4'hF; m_frame = 16'd0;
      m_row = 4'b1110; m_code = 4'd0;
      m_held = 0; m_valid = 0; m_release = 0;
   endtask

   task automatic model_edge();
      m_sampled = m_hist2;
      m_hist2 = m_hist1;
      m_hist1 = kp.col;
      m_n++;
      m_valid = 0;
      m_release = 0;
      if (m_due == m_n) begin
         if (!m_held && m_pend >= 0 && m_pend < 16) begin
            m_held = 1; m_code = 4'(m_pend); m_valid = 1;
         end else if (m_held && m_pend < 0) begin
            m_held = 0; m_release = 1;
         end
         m_due = -1;
      end
      if (m_n % T == 0) begin
         m_ri = ((m_n / T) - 1) % 4;
         m_frame[m_ri*4 +: 4] = ~m_sampled;
         if (m_ri == 3) begin
            m_cls = classify(m_frame);
            if (m_cls != m_last) begin m_last = m_cls; m_run = 0; end
            if (m_run < S) begin
               m_run++;
               if (m_run == S) begin m_due = m_n + 2; m_pend = m_cls; end
            end
         end
      end
      m_row = ~(4'b0001 << ((m_n / T) % 4));
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_edge();
      end
   end

   initial forever begin
      @(negedge clk);
      if (kp.key_valid) ev_valid++;
      if (kp.key_release) ev_rel++;
      if (chk_en) begin
         check("row", kp.row, m_row);
         check("key_code", kp.key_code, m_code);
         check("key_valid", kp.key_valid, m_valid);
         check("key_held", kp.key_held, m_held);
         check("key_release", kp.key_release, m_release);
      end
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int v0, r0, lat;

   initial begin
      clks(3);
      check("reset_row", kp.row, 4'b1110);
      check("reset_code", kp.key_code, 0);
      check("reset_valid", kp.key_valid, 0);
      check("reset_held", kp.key_held, 0);
      check("reset_release", kp.key_release, 0);
      chk_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      // Row strobe sequence, ten clocks per row
      clks(5);  check("row_seq0", kp.row, 4'b1110);
      clks(10); check("row_seq1", kp.row, 4'b1101);
      clks(10); check("row_seq2", kp.row, 4'b1011);
      clks(10); check("row_seq3", kp.row, 4'b0111);
      clks(10); check("row_seq4", kp.row, 4'b1110);
      clks(355);
      check("idle_valid", ev_valid, 0);
      check("idle_release", ev_rel, 0);

      // Key (r2,c1) held six frames then released
      v0 = ev_valid; r0 = ev_rel;
      pressed = 16'd1 << 9;
      clks(240);
      check("k9_valid_cnt", ev_valid - v0, 1);
      check("k9_code", kp.key_code, 9);
      check("k9_held", kp.key_held, 1);
      pressed = 16'd0;
      clks(240);
      check("k9_release_cnt", ev_rel - r0, 1);
      check("k9_held_after", kp.key_held, 0);
      check("k9_code_kept", kp.key_code, 9);

      // Bounce on key 4
      v0 = ev_valid;
      pressed = 16'd1 << 4; clks(40);
      pressed = 16'd0;      clks(40);
      pressed = 16'd1 << 4; clks(40);
      pressed = 16'd0;      clks(200);
      check("bounce_valid_cnt", ev_valid - v0, 0);
      check("bounce_held", kp.key_held, 0);

      // Two keys at once, then roll-over from 3 to 7
      v0 = ev_valid; r0 = ev_rel;
      pressed = 16'h0021; clks(200);
      check("multi_valid_cnt", ev_valid - v0, 0);
      pressed = 16'd0; clks(200);
      pressed = 16'd1 << 3; clks(200);
      check("k3_valid_cnt", ev_valid - v0, 1);
      check("k3_code", kp.key_code, 3);
      pressed = 16'h0088; clks(200);
      pressed = 16'd1 << 7; clks(200);
      check("roll_valid_cnt", ev_valid - v0, 1);
      check("roll_code", kp.key_code, 3);
      check("roll_held", kp.key_held, 1);
      pressed = 16'd0; clks(200);
      check("roll_release_cnt", ev_rel - r0, 1);

      // Asynchronous reset while key 12 is held
      pressed = 16'd1 << 12; clks(200);
      check("k12_held_pre", kp.key_held, 1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("arst_row", kp.row, 4'b1110);
      check("arst_code", kp.key_code, 0);
      check("arst_held", kp.key_held, 0);
      check("arst_valid", kp.key_valid, 0);
      check("arst_release", kp.key_release, 0);
      clks(3);
      @(negedge clk);
      rst_n = 1'b1;
      lat = 0;
      for (int j = 1; j <= 300; j++) begin
         @(negedge clk);
         if (kp.key_valid && lat == 0) lat = j;
      end
      check("k12_latency", lat, 122);
      check("k12_code", kp.key_code, 12);
      #1;
      pressed = 16'd0; clks(200);

      // Corner codes
      pressed = 16'd1 << 0; clks(200);
      check("k0_code", kp.key_code, 0);
      check("k0_held", kp.key_held, 1);
      pressed = 16'd0; clks(200);
      pressed = 16'd1 << 15; clks(200);
      check("k15_code", kp.key_code, 15);
      pressed = 16'd0; clks(200);
      check("k15_released", kp.key_held, 0);

      // Random key patterns, durations and one mid-run reset
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 3))
            0: pressed = 16'd0;
            1, 2: pressed = 16'd1 << $urandom_range(0, 15);
            default: pressed = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
         endcase
         clks($urandom_range(5, 200));
         if (it == 20) begin
            #($urandom_range(1, 8));
            rst_n = 1'b0;
            clks($urandom_range(1, 5));
            rst_n = 1'b1;
         end
      end
      pressed = 16'd0;
      clks(200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
